// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register, decoder and Moore sequencer for the simple RISC datapath
module cpu_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_REG, S_HALT
  } state_t;

  state_t      state, state_next;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

  assign opcode     = ir[15:13];
  assign op         = ir[12:11];
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_next;
      if (load && (state == S_WAIT)) ir <= in;
    end
  end

  always_comb begin
    state_next = S_WAIT;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = 2'b00;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (state)
      S_WAIT: begin
        w          = 1'b1;
        state_next = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        if (is_mov_imm)                state_next = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_next = S_GET_B;
        else if (is_alu)               state_next = S_GET_A;
        else if (HALT_ON_ILLEGAL)      state_next = S_HALT;
        else                           state_next = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum   = ir[10:8];
        vsel       = 2'b10;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_GET_A: begin
        readnum    = ir[10:8];
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum    = ir[2:0];
        loadb      = 1'b1;
        state_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        // MOV reg and MVN have no A operand: zero it and let the ALU pass/invert B
        shift      = ir[4:3];
        loadc      = 1'b1;
        asel       = is_mov_reg || is_mvn;
        ALUop      = is_mov_reg ? 2'b00 : op;
        loads      = is_cmp;
        state_next = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        writenum   = ir[7:5];
        vsel       = 2'b00;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller with a phase-list reference model
module tb_cpu_controller;

  logic clk, reset_n, reset_h, s, s_h, load, load_h;
  logic [15:0] in;

  logic        w, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  logic        h_w, h_write, h_loada, h_loadb, h_asel, h_bsel, h_loadc, h_loads;
  logic [2:0]  h_readnum, h_writenum;
  logic [1:0]  h_vsel, h_shift, h_ALUop;
  logic [15:0] h_sximm5, h_sximm8;

  int checks = 0;
  int errors = 0;

  cpu_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .sximm5(sximm5), .sximm8(sximm8)
  );

  cpu_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .reset_n(reset_h), .s(s_h), .load(load_h), .in(in), .w(h_w),
    .readnum(h_readnum), .writenum(h_writenum), .vsel(h_vsel), .write(h_write),
    .loada(h_loada), .loadb(h_loadb), .asel(h_asel), .bsel(h_bsel), .shift(h_shift),
    .ALUop(h_ALUop), .loadc(h_loadc), .loads(h_loads), .sximm5(h_sximm5), .sximm8(h_sximm8)
  );

  logic [51:0] act_vec, h_vec;
  assign act_vec = {w, readnum, writenum, vsel, write, loada, loadb, asel, bsel,
                    shift, ALUop, loadc, loads, sximm5, sximm8};
  assign h_vec   = {h_w, h_readnum, h_writenum, h_vsel, h_write, h_loada, h_loadb, h_asel, h_bsel,
                    h_shift, h_ALUop, h_loadc, h_loads, h_sximm5, h_sximm8};

  always #5 clk = ~clk;

  // Phases of an instruction, one per cycle: -1 idle, 0 decode, 1 write imm,
  // 2 read Rn, 3 read Rm, 4 compute, 5 write Rd.
  function automatic logic [51:0] expv(int ph, logic [15:0] ir);
    logic       ew, ewr, ela, elb, eas, elc, els;
    logic [2:0] ern, ewn;
    logic [1:0] evs, esh, eal, op;
    logic [2:0] opc;
    logic signed [15:0] s5, s8;
    opc = ir[15:13]; op = ir[12:11];
    ew = 0; ewr = 0; ela = 0; elb = 0; eas = 0; elc = 0; els = 0;
    ern = 0; ewn = 0; evs = 0; esh = 0; eal = 0;
    s5 = $signed(ir[4:0]);
    s8 = $signed(ir[7:0]);
    case (ph)
      -1: ew = 1;
      1: begin ewn = ir[10:8]; evs = 2'b10; ewr = 1; end
      2: begin ern = ir[10:8]; ela = 1; end
      3: begin ern = ir[2:0]; elb = 1; end
      4: begin
        esh = ir[4:3]; elc = 1;
        eas = (opc == 3'd6) || (op == 2'd3);
        eal = (opc == 3'd6) ? 2'd0 : op;
        els = (opc == 3'd5) && (op == 2'd1);
      end
      5: begin ewn = ir[7:5]; ewr = 1; end
      default: ;
    endcase
    return {ew, ern, ewn, evs, ewr, ela, elb, eas, 1'b0, esh, eal, elc, els, s5, s8};
  endfunction

  int          mq[$];
  logic [15:0] mir = 16'h0;
  logic [51:0] ev;

  always begin
    @(posedge clk);
    if (!reset_n) begin
      mq.delete();
      mir = 16'h0;
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
    end else begin
      if (load) mir = in;
      if (s) begin
        mq.push_back(0);
        if (mir[15:11] == 5'b11010)      mq.push_back(1);
        else if (mir[15:11] == 5'b11000) begin mq.push_back(3); mq.push_back(4); mq.push_back(5); end
        else if (mir[15:13] == 3'b101) begin
          if (mir[12:11] != 2'b11) mq.push_back(2);
          mq.push_back(3); mq.push_back(4);
          if (mir[12:11] != 2'b01) mq.push_back(5);
        end
      end
    end
    #1;
    ev = (!reset_n) ? expv(-1, 16'h0) : expv((mq.size() > 0) ? mq[0] : -1, mir);
    checks++;
    if (act_vec !== ev) begin
      errors++;
      $display("FAIL model_cycle t=%0t act=%h exp=%h", $time, act_vec, ev);
    end
  end

  task automatic chk(string name, logic [51:0] act, logic [51:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic issue(logic [15:0] word, logic ld);
    @(negedge clk);
    in = word; load = ld; s = 1;
    @(negedge clk);
    load = 0; s = 0;
  endtask

  task automatic run_lat(logic [15:0] word, int lat);
    int n;
    issue(word, 1'b1);
    n = 0;
    while (!w && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency_%h", word), 52'(n), 52'(lat));
  endtask

  initial begin
    clk = 0; reset_n = 0; reset_h = 0; s = 0; s_h = 0; load = 0; load_h = 0; in = 0;
    #2;
    chk("reset_vec", act_vec, {1'b1, 51'b0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1; reset_h = 1;

    // MOV R0,#-5
    issue(16'hD0FB, 1'b1);
    chk("movi_decode_w", 52'(w), 52'd0);
    @(negedge clk);
    chk("movi_wimm", {writenum, vsel, write, sximm8}, {3'd0, 2'b10, 1'b1, 16'hFFFB});
    @(negedge clk);
    chk("movi_done_w", 52'(w), 52'd1);

    // ADD R2,R1,R0,LSL#1
    issue(16'hA148, 1'b1);
    @(negedge clk);
    chk("add_get_a", {readnum, loada, loadb}, {3'd1, 1'b1, 1'b0});
    @(negedge clk);
    chk("add_get_b", {readnum, loada, loadb}, {3'd0, 1'b0, 1'b1});
    @(negedge clk);
    chk("add_compute", {ALUop, shift, asel, loadc, write}, {2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("add_write", {writenum, vsel, write, loadc}, {3'd2, 2'b00, 1'b1, 1'b0});
    @(negedge clk);
    chk("add_done_w", 52'(w), 52'd1);

    // CMP R3,R4
    issue(16'hAB04, 1'b1);
    repeat (3) @(negedge clk);
    chk("cmp_compute", {ALUop, loads, loadc, write}, {2'b01, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    chk("cmp_done_w", 52'(w), 52'd1);

    // MVN R5,R6 with a load attempt while busy
    issue(16'hB8A6, 1'b1);
    @(negedge clk);
    chk("mvn_get_b", {readnum, loada, loadb}, {3'd6, 1'b0, 1'b1});
    @(negedge clk);
    chk("mvn_compute", {asel, ALUop, loadc}, {1'b1, 2'b11, 1'b1});
    in = 16'hFFFF; load = 1;
    @(negedge clk);
    load = 0;
    chk("mvn_write", {writenum, write, sximm8, sximm5}, {3'd5, 1'b1, 16'hFFA6, 16'h0006});
    @(negedge clk);
    chk("mvn_done_w", 52'(w), 52'd1);

    // Reset during GET_B of an ADD
    issue(16'hA148, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_pre_loadb", 52'(loadb), 52'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_mid", {w, write, loada, loadb, loadc}, {1'b1, 4'b0000});
    @(negedge clk);
    reset_n = 1;
    issue(16'hFFFF, 1'b0);
    chk("rst_ill_decode", act_vec, 52'd0);
    @(negedge clk);
    chk("rst_ill_done", act_vec, {1'b1, 51'b0});

    // Latency table, illegal encodings and an s pulse while busy
    run_lat(16'hB6E9, 5);
    run_lat(16'hC0F9, 4);
    run_lat(16'h0000, 1);
    run_lat(16'hE000, 1);
    run_lat(16'hD800, 1);
    run_lat(16'hD07F, 2);
    issue(16'hB6E9, 1'b1);
    @(negedge clk);
    s = 1; load = 1; in = 16'h1234;
    @(negedge clk);
    s = 0; load = 0;
    repeat (4) @(negedge clk);
    chk("busy_s_ignored", {w, sximm8}, {1'b1, 16'hFFE9});

    // HALT_ON_ILLEGAL=1 with IR=0
    chk("halt_pre_w", 52'(h_w), 52'd1);
    @(negedge clk);
    s_h = 1;
    @(negedge clk);
    s_h = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("halt_hold_%0d", i), h_vec, 52'd0);
      s_h = 1;
    end
    s_h = 0;
    reset_h = 0;
    #1;
    chk("halt_reset_w", 52'(h_w), 52'd1);
    @(negedge clk);
    reset_h = 1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
